neuron_host_seq: RTL

NEURON_HOST_SEQ -- requirements
Module: neuron_host_seq

---
 rtl/neuron_host_seq_if.sv | 39 +++
 rtl/neuron_host_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/neuron_host_seq_if.sv
// Host/engine signal bundle for neuron_host_seq. The master side is the host plus
// the engine model; the slave side is the sequencer itself.
interface neuron_host_seq_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned THR_W  = 16,
  parameter int unsigned RES_W  = 16
) ();
  logic              start;
  logic [THR_W-1:0]  thr_in;
  logic              src_valid;
  logic              src_ready;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              chip_sel;
  logic              wr_en;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [THR_W-1:0]  threshold;
  logic              threshold_ready;
  logic              output_ready;
  logic [RES_W-1:0]  result_in;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic              busy;
  logic              err;

  modport master (
    output start, thr_in, src_valid, src_a, src_b, output_ready, result_in, res_ready,
    input  src_ready, chip_sel, wr_en, data_a, data_b, threshold, threshold_ready,
    input  res_valid, res_data, busy, err
  );

  modport slave (
    input  start, thr_in, src_valid, src_a, src_b, output_ready, result_in, res_ready,
    output src_ready, chip_sel, wr_en, data_a, data_b, threshold, threshold_ready,
    output res_valid, res_data, busy, err
  );
endinterface

// File: rtl/neuron_host_seq.sv
// Job sequencer: buffers N_PAIRS operand pairs from the host, bursts them into the
// neuron engine, strobes the threshold, waits (bounded) for the result and hands it back.
// Every output is a register loaded from the next-state decode, so outputs line up
// with the state they belong to and no input reaches an output combinationally.
module neuron_host_seq #(
  parameter int unsigned N_PAIRS = 64,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned THR_W   = 16,
  parameter int unsigned RES_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  neuron_host_seq_if.slave bus
);

  localparam int unsigned IdxW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam int unsigned CntW = $clog2(N_PAIRS) + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StBurst, StThresh, StWaitRes, StResult, StGap, StError
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  gap_q, gap_d;
  logic [THR_W-1:0]      thr_q;
  logic [2*DATA_W-1:0]   buf_q [N_PAIRS];

  logic                  chip_sel_q, wr_en_q, thr_rdy_q, src_ready_q, res_valid_q;
  logic                  busy_q, err_q;
  logic [DATA_W-1:0]     data_a_q, data_b_q;
  logic [THR_W-1:0]      threshold_q;
  logic [RES_W-1:0]      res_data_q;

  logic                  accept;
  logic                  start_acc;
  logic [IdxW-1:0]       rd_idx;
  logic [2*DATA_W-1:0]   rd_pair;

  assign accept    = (state_q == StLoad) && bus.src_valid && src_ready_q;
  assign start_acc = (state_q == StIdle) && bus.start;

  // Next-state logic; cnt doubles as the load index and the burst index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          if (cnt_q == CntW'(N_PAIRS - 1)) begin
            state_d = StBurst;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StBurst: begin
        if (cnt_q == CntW'(N_PAIRS - 1)) begin
          state_d = StThresh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StThresh: begin
        state_d = StWaitRes;
        tmo_d   = '0;
      end
      StWaitRes: begin
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (bus.output_ready) begin
          state_d = StResult;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          state_d = StError;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StResult: begin
        if (res_valid_q && bus.res_ready) begin
          state_d = StGap;
          gap_d   = 1'b0;
        end
      end
      StGap: begin
        if (gap_q) begin
          state_d = StIdle;
        end else begin
          gap_d = 1'b1;
        end
      end
      StError: begin
        state_d = StGap;
        gap_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand for the next burst cycle; bypass covers a pair written on the same edge.
  always_comb begin
    rd_idx  = cnt_d[IdxW-1:0];
    rd_pair = buf_q[rd_idx];
    if (accept && (cnt_q[IdxW-1:0] == rd_idx)) begin
      rd_pair = {bus.src_a, bus.src_b};
    end
  end

  // Pair buffer; intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q[cnt_q[IdxW-1:0]] <= {bus.src_a, bus.src_b};
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tmo_q       <= '0;
      gap_q       <= 1'b0;
      thr_q       <= '0;
      chip_sel_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      thr_rdy_q   <= 1'b0;
      src_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      threshold_q <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      if (start_acc) begin
        thr_q <= bus.thr_in;
      end
      chip_sel_q  <= (state_d == StBurst) || (state_d == StThresh) || (state_d == StWaitRes);
      wr_en_q     <= (state_d == StBurst);
      thr_rdy_q   <= (state_d == StThresh);
      src_ready_q <= (state_d == StLoad);
      res_valid_q <= (state_d == StResult);
      busy_q      <= (state_d != StIdle);
      if (state_d == StBurst) begin
        {data_a_q, data_b_q} <= rd_pair;
      end else begin
        {data_a_q, data_b_q} <= '0;
      end
      if (state_d == StIdle) begin
        threshold_q <= '0;
      end else if (state_d == StThresh) begin
        threshold_q <= thr_q;
      end
      if ((state_q == StWaitRes) && bus.output_ready) begin
        res_data_q <= bus.result_in;
      end
      if (start_acc) begin
        err_q <= 1'b0;
      end else if (state_d == StError) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.src_ready       = src_ready_q;
  assign bus.chip_sel        = chip_sel_q;
  assign bus.wr_en           = wr_en_q;
  assign bus.data_a          = data_a_q;
  assign bus.data_b          = data_b_q;
  assign bus.threshold       = threshold_q;
  assign bus.threshold_ready = thr_rdy_q;
  assign bus.res_valid       = res_valid_q;
  assign bus.res_data        = res_data_q;
  assign bus.busy            = busy_q;
  assign bus.err             = err_q;

endmodule
